// File: rtl/npu_regfile_pkg.sv
// Shared constants, types and helpers for the NPU register-file client.
// Contents: XLEN/NREG/AW widths, reg_addr_t / xword_t, client_state_t FSM
// encoding (also exposed as plain localparams for legacy users), and the
// per-source scoreboard hazard helper.
package npu_regfile_pkg;

   localparam int unsigned XLEN = 64;
   localparam int unsigned NREG = 32;
   localparam int unsigned AW   = $clog2(NREG);

   typedef logic [AW-1:0]   reg_addr_t;
   typedef logic [XLEN-1:0] xword_t;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_HAZARD = 2'd1;
   localparam logic [1:0] ST_READ   = 2'd2;
   localparam logic [1:0] ST_HOLD   = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      HAZARD = ST_HAZARD,
      READ   = ST_READ,
      HOLD   = ST_HOLD
   } client_state_t;

   // A source waits only on a real register with an outstanding write; x0 never does.
   function automatic logic src_hazard(input reg_addr_t rs, input logic [NREG-1:0] pend);
      return (rs != '0) && pend[rs];
   endfunction

endpackage

// File: rtl/npu_wb_stage.sv
// Registered writeback stage driving regfile write port B.
// Ports: clk, rst_n; wb_valid/wb_rd/wb_data (NPU writeback, always accepted);
//        write_enable_b/write_addr_b/write_data_b (port B, one cycle later).
// Writes targeting x0 are dropped by never raising write_enable_b.
module npu_wb_stage
   import npu_regfile_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wb_valid,
   input  logic [AW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            write_enable_b,
   output logic [AW-1:0]   write_addr_b,
   output logic [XLEN-1:0] write_data_b
);

   // One register stage; address/data follow the bus every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_enable_b <= 1'b0;
         write_addr_b   <= '0;
         write_data_b   <= '0;
      end else begin
         write_enable_b <= wb_valid && (wb_rd != '0);
         write_addr_b   <= wb_rd;
         write_data_b   <= wb_data;
      end
   end

endmodule

// File: rtl/npu_regfile_client.sv
// NPU-side master for the register file external interface.
// Accepts an rs1/rs2 operand request, waits while the scoreboard flags either
// source as pending, reads the regfile (forwarding the port-B write that lands
// on the capture edge), and holds the operands on a valid/ready channel.
// Also owns regfile write port B through npu_wb_stage.
// Ports: req_* (operand request), op_* (operand result), wb_* (writeback in),
//        ext_address*/ext_data* (regfile read), reg_pending_writes (scoreboard),
//        write_*_b (port B out).
// Optional: define NPU_REGFILE_CLIENT_STALL_CNT_EN to add the saturating
//        stall_cycles counter output.
module npu_regfile_client
   import npu_regfile_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [AW-1:0]   req_rs1,
   input  logic [AW-1:0]   req_rs2,
   output logic            op_valid,
   input  logic            op_ready,
   output logic [XLEN-1:0] op_a,
   output logic [XLEN-1:0] op_b,
   input  logic            wb_valid,
   input  logic [AW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic [AW-1:0]   ext_address1,
   output logic [AW-1:0]   ext_address2,
   input  logic [XLEN-1:0] ext_data1,
   input  logic [XLEN-1:0] ext_data2,
   input  logic [NREG-1:0] reg_pending_writes,
   output logic            write_enable_b,
   output logic [AW-1:0]   write_addr_b,
   output logic [XLEN-1:0] write_data_b
`ifdef NPU_REGFILE_CLIENT_STALL_CNT_EN
   ,
   output logic [31:0]     stall_cycles
`endif
);

   client_state_t state;
   client_state_t state_nxt;
   logic          accept_c;
   logic          hazard_c;
   xword_t        fwd1_c;
   xword_t        fwd2_c;

   // Writeback path runs independently of the operand FSM.
   npu_wb_stage u_wb_stage (
      .clk            (clk),
      .rst_n          (rst_n),
      .wb_valid       (wb_valid),
      .wb_rd          (wb_rd),
      .wb_data        (wb_data),
      .write_enable_b (write_enable_b),
      .write_addr_b   (write_addr_b),
      .write_data_b   (write_data_b)
   );

   assign req_ready = (state == IDLE);
   assign accept_c  = req_valid && req_ready;
   assign hazard_c  = src_hazard(reg_addr_t'(ext_address1), reg_pending_writes)
                   || src_hazard(reg_addr_t'(ext_address2), reg_pending_writes);

   // Regfile data is stale for a port-B write landing on this edge, so bypass it.
   always_comb begin
      fwd1_c = ext_data1;
      fwd2_c = ext_data2;
      if (ext_address1 == '0) begin
         fwd1_c = '0;
      end else if (write_enable_b && (write_addr_b == ext_address1)) begin
         fwd1_c = write_data_b;
      end
      if (ext_address2 == '0) begin
         fwd2_c = '0;
      end else if (write_enable_b && (write_addr_b == ext_address2)) begin
         fwd2_c = write_data_b;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept_c) state_nxt = HAZARD;
         HAZARD:  if (!hazard_c) state_nxt = READ;
         READ:    state_nxt = HOLD;
         HOLD:    if (op_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request address latch and operand capture/hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ext_address1 <= '0;
         ext_address2 <= '0;
         op_valid     <= 1'b0;
         op_a         <= '0;
         op_b         <= '0;
      end else begin
         if (accept_c) begin
            ext_address1 <= req_rs1;
            ext_address2 <= req_rs2;
         end
         if (state == READ) begin
            op_a     <= fwd1_c;
            op_b     <= fwd2_c;
            op_valid <= 1'b1;
         end else if ((state == HOLD) && op_ready) begin
            op_valid <= 1'b0;
         end
      end
   end

`ifdef NPU_REGFILE_CLIENT_STALL_CNT_EN
   // Saturating count of cycles blocked by the scoreboard.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if ((state == HAZARD) && hazard_c && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_npu_regfile_client.sv
module tb_npu_regfile_client;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [4:0]  req_rs1 = '0;
   logic [4:0]  req_rs2 = '0;
   logic        op_valid;
   logic        op_ready = 1'b0;
   logic [63:0] op_a;
   logic [63:0] op_b;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [63:0] wb_data = '0;
   logic [4:0]  ext_address1;
   logic [4:0]  ext_address2;
   logic [63:0] ext_data1;
   logic [63:0] ext_data2;
   logic [31:0] pend = '0;
   logic        write_enable_b;
   logic [4:0]  write_addr_b;
   logic [63:0] write_data_b;
`ifdef NPU_REGFILE_CLIENT_STALL_CNT_EN
   logic [31:0] stall_cycles;
`endif

   // Register file model: combinational read, port-B write at the clock edge.
   logic [63:0] regs [32];
   logic        force1 = 1'b0;
   assign ext_data1 = force1 ? 64'hffff : regs[ext_address1];
   assign ext_data2 = regs[ext_address2];
   always @(posedge clk) if (write_enable_b) regs[write_addr_b] <= write_data_b;

   always #5 clk = ~clk;

   npu_regfile_client dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .req_valid          (req_valid),
      .req_ready          (req_ready),
      .req_rs1            (req_rs1),
      .req_rs2            (req_rs2),
      .op_valid           (op_valid),
      .op_ready           (op_ready),
      .op_a               (op_a),
      .op_b               (op_b),
      .wb_valid           (wb_valid),
      .wb_rd              (wb_rd),
      .wb_data            (wb_data),
      .ext_address1       (ext_address1),
      .ext_address2       (ext_address2),
      .ext_data1          (ext_data1),
      .ext_data2          (ext_data2),
      .reg_pending_writes (pend),
      .write_enable_b     (write_enable_b),
      .write_addr_b       (write_addr_b),
      .write_data_b       (write_data_b)
`ifdef NPU_REGFILE_CLIENT_STALL_CNT_EN
      ,
      .stall_cycles       (stall_cycles)
`endif
   );

   typedef struct {
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [63:0] va;
      logic [63:0] vb;
      int          stall;     // cycles rs1 stays pending after accept
      bit          fwd;       // writeback to rs1 lands on the capture edge
      bit          frc;       // force ext_data1 to 0xffff
      int          hold;      // cycles op_ready stays low in HOLD
      logic [63:0] exp_a;
      logic [63:0] exp_b;
      int          exp_lat;
      int          exp_stall;
   } vec_t;

   vec_t vecs[5];
   logic [127:0] sb_q[$];
   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic wb_write(input logic [4:0] rd, input logic [63:0] d);
      @(negedge clk);
      wb_valid = 1'b1; wb_rd = rd; wb_data = d;
      @(negedge clk);
      wb_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v);
      int n;
      bit seen;
      logic [127:0] e;
`ifdef NPU_REGFILE_CLIENT_STALL_CNT_EN
      logic [31:0] st0;
`endif
      if (v.rs1 != 0) wb_write(v.rs1, v.va);
      if (v.rs2 != 0) wb_write(v.rs2, v.vb);
      force1 = v.frc;
      @(negedge clk);
      chk("req_ready_idle", 64'(req_ready), 64'd1);
`ifdef NPU_REGFILE_CLIENT_STALL_CNT_EN
      st0 = stall_cycles;
`endif
      req_valid = 1'b1; req_rs1 = v.rs1; req_rs2 = v.rs2;
      op_ready = (v.hold == 0);
      pend = (v.stall > 0) ? (32'd1 << v.rs1) : 32'd0;
      sb_q.push_back({v.exp_a, v.exp_b});
      @(negedge clk);
      req_valid = 1'b0;
      chk("ext_address1", 64'(ext_address1), 64'(v.rs1));
      chk("ext_address2", 64'(ext_address2), 64'(v.rs2));
      n = 1;
      seen = 0;
      while (n <= 40) begin
         if (op_valid) begin
            seen = 1;
            break;
         end
         pend = (n <= v.stall) ? (32'd1 << v.rs1) : 32'd0;
         if (v.fwd && n == 1) begin
            wb_valid = 1'b1; wb_rd = v.rs1; wb_data = v.exp_a;
         end else if (v.fwd && n == 2) begin
            wb_valid = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      pend = '0;
      wb_valid = 1'b0;
      chk("op_valid_seen", 64'(seen), 64'd1);
      chk("latency", 64'(n), 64'(v.exp_lat));
      for (int h = 0; h < v.hold && seen; h++) begin
         chk("hold_valid", 64'(op_valid), 64'd1);
         chk("hold_op_a", op_a, v.exp_a);
         chk("hold_op_b", op_b, v.exp_b);
         chk("hold_req_ready", 64'(req_ready), 64'd0);
         @(negedge clk);
      end
      op_ready = 1'b1;
      if (sb_q.size() == 0) begin
         chk("scoreboard_empty", 64'd1, 64'd0);
      end else begin
         e = sb_q.pop_front();
         chk("op_a", op_a, e[127:64]);
         chk("op_b", op_b, e[63:0]);
      end
      @(negedge clk);
      op_ready = 1'b0;
      force1 = 1'b0;
      chk("op_valid_drop", 64'(op_valid), 64'd0);
      chk("req_ready_back", 64'(req_ready), 64'd1);
`ifdef NPU_REGFILE_CLIENT_STALL_CNT_EN
      chk("stall_cycles", 64'(stall_cycles - st0), 64'(v.exp_stall));
`endif
      if (!seen) begin
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      vecs[0] = '{5'd5, 5'd10, 64'hdeadbeefdeadbeef, 64'hcafef00dcafef00d, 0, 0, 0, 0,
                  64'hdeadbeefdeadbeef, 64'hcafef00dcafef00d, 3, 0};
      vecs[1] = '{5'd5, 5'd10, 64'hdeadbeefdeadbeef, 64'hcafef00dcafef00d, 4, 0, 0, 0,
                  64'hdeadbeefdeadbeef, 64'hcafef00dcafef00d, 7, 4};
      vecs[2] = '{5'd5, 5'd10, 64'h5555, 64'hcafef00dcafef00d, 0, 1, 0, 0,
                  64'h1111, 64'hcafef00dcafef00d, 3, 0};
      vecs[3] = '{5'd0, 5'd10, 64'h0, 64'h0a0a0a0a0a0a0a0a, 4, 0, 1, 0,
                  64'h0, 64'h0a0a0a0a0a0a0a0a, 3, 0};
      vecs[4] = '{5'd3, 5'd7, 64'h0123456789abcdef, 64'hfedcba9876543210, 0, 0, 0, 5,
                  64'h0123456789abcdef, 64'hfedcba9876543210, 3, 0};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_op_valid", 64'(op_valid), 64'd0);
      chk("rst_op_a", op_a, 64'd0);
      chk("rst_op_b", op_b, 64'd0);
      chk("rst_ext_address1", 64'(ext_address1), 64'd0);
      chk("rst_write_enable_b", 64'(write_enable_b), 64'd0);
      chk("rst_write_data_b", write_data_b, 64'd0);
`ifdef NPU_REGFILE_CLIENT_STALL_CNT_EN
      chk("rst_stall_cycles", 64'(stall_cycles), 64'd0);
`endif
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // Writeback path: x0 dropped, other registers passed one cycle later
      @(negedge clk);
      wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 64'hffff;
      @(negedge clk);
      chk("wb_x0_enable", 64'(write_enable_b), 64'd0);
      wb_rd = 5'd12; wb_data = 64'habc;
      @(negedge clk);
      chk("wb_enable", 64'(write_enable_b), 64'd1);
      chk("wb_addr", 64'(write_addr_b), 64'd12);
      chk("wb_data", write_data_b, 64'habc);
      wb_valid = 1'b0;
      @(negedge clk);
      chk("wb_enable_off", 64'(write_enable_b), 64'd0);

      // Reset asserted while holding operands
      @(negedge clk);
      req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd10; op_ready = 1'b0;
      sb_q.push_back({64'hdeadbeefdeadbeef, 64'hcafef00dcafef00d});
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!op_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rst_hold_reached", 64'(op_valid), 64'd1);
      wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 64'h77;
      @(negedge clk);
      chk("pre_rst_write_enable_b", 64'(write_enable_b), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("async_op_valid", 64'(op_valid), 64'd0);
      chk("async_write_enable_b", 64'(write_enable_b), 64'd0);
      chk("async_ext_address1", 64'(ext_address1), 64'd0);
      chk("async_ext_address2", 64'(ext_address2), 64'd0);
      chk("async_op_a", op_a, 64'd0);
      chk("async_req_ready", 64'(req_ready), 64'd1);
      sb_q.delete();
      wb_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run_vec(vecs[0]);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
